// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and default constants for the fetch-address
//               sequencer: state enum, default width, step, boot vectors
//               and interrupt entry address.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Sequencer operating states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int unsigned C_ADDR_W   = 32;
    localparam int unsigned C_NUM_VECT = 4;
    localparam int unsigned C_SEL_W    = 2;
    localparam int unsigned C_STEP     = 4;

    // Entry i lives at bits [i*C_ADDR_W +: C_ADDR_W]: entry0=0, 1=15, 2=25, 3=75
    localparam logic [C_NUM_VECT*C_ADDR_W-1:0] C_BOOT_VECTORS =
        {32'd75, 32'd25, 32'd15, 32'd0};

    localparam logic [C_ADDR_W-1:0] C_IRQ_VECTOR = 32'h0000_0080;

endpackage
`default_nettype wire

// File: rtl/pc_boot_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_boot_mux
// Description : Combinational NUM_VECT-way boot vector select. A select
//               value with no matching entry falls back to entry 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_boot_mux
    import pc_pkg::*;
#(
    parameter int unsigned                 ADDR_W       = C_ADDR_W,
    parameter int unsigned                 NUM_VECT     = C_NUM_VECT,
    parameter int unsigned                 SEL_W        = C_SEL_W,
    parameter logic [NUM_VECT*ADDR_W-1:0]  BOOT_VECTORS = C_BOOT_VECTORS
) (
    input  logic [SEL_W-1:0]  i_sel,
    output logic [ADDR_W-1:0] o_vector
);

    logic [ADDR_W-1:0] w_table [NUM_VECT];

    for (genvar gi = 0; gi < NUM_VECT; gi++) begin : g_unpack
        assign w_table[gi] = BOOT_VECTORS[gi*ADDR_W +: ADDR_W];
    end

    // Pick the matching entry; anything out of range keeps the entry-0 default
    always_comb begin
        o_vector = w_table[0];
        for (int i = 0; i < NUM_VECT; i++) begin
            if (32'(i_sel) == 32'(i)) begin
                o_vector = w_table[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-address sequencer. Loads a boot vector on reset, spends
//               one cycle in BOOT, then advances by STEP per cycle in RUN with
//               stall, aligned redirect and a HALT/resume state.
//               Optional interrupt entry/return enabled by macro PC_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned                 ADDR_W       = C_ADDR_W,
    parameter int unsigned                 NUM_VECT     = C_NUM_VECT,
    parameter int unsigned                 SEL_W        = C_SEL_W,
    parameter logic [NUM_VECT*ADDR_W-1:0]  BOOT_VECTORS = C_BOOT_VECTORS,
    parameter int unsigned                 STEP         = C_STEP
`ifdef PC_IRQ_EN
    ,
    parameter logic [ADDR_W-1:0]           IRQ_VECTOR   = C_IRQ_VECTOR
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SEL_W-1:0]  boot_sel,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              align_err
`ifdef PC_IRQ_EN
    ,
    input  logic              irq,
    input  logic              eret,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc
`endif
);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_boot_vec;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_redir_misaligned;
    logic              r_pc_valid;
    logic              r_align_err;
    logic              w_align_nxt;
`ifdef PC_IRQ_EN
    logic              r_ie;
    logic              w_ie_nxt;
    logic              r_irq_ack;
    logic              w_irq_ack_nxt;
    logic [ADDR_W-1:0] r_epc;
    logic [ADDR_W-1:0] w_epc_nxt;
`endif

    pc_boot_mux #(
        .ADDR_W       (ADDR_W),
        .NUM_VECT     (NUM_VECT),
        .SEL_W        (SEL_W),
        .BOOT_VECTORS (BOOT_VECTORS)
    ) u_boot_mux (
        .i_sel    (boot_sel),
        .o_vector (w_boot_vec)
    );

    // Low two bits are forced to zero on a redirect; a nonzero pair is flagged
    assign w_seq_pc           = r_pc + ADDR_W'(STEP);
    assign w_redir_pc         = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign w_redir_misaligned = |redirect_addr[1:0];

    // Next-state and next-pc selection; every output defaults to "hold"
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_align_nxt = 1'b0;
`ifdef PC_IRQ_EN
        w_ie_nxt      = r_ie;
        w_irq_ack_nxt = 1'b0;
        w_epc_nxt     = r_epc;
`endif
        case (r_state)
            BOOT: begin
                // The boot vector itself is the first valid fetch
                w_state_nxt = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_align_nxt = w_redir_misaligned;
                end else if (!stall) begin
                    w_pc_nxt = w_seq_pc;
                end
`ifdef PC_IRQ_EN
                // Return beats entry, entry beats redirect; an overridden
                // redirect is not accepted and therefore raises no flag
                if (eret) begin
                    w_pc_nxt    = r_epc;
                    w_ie_nxt    = 1'b1;
                    w_align_nxt = 1'b0;
                end else if (irq && r_ie && !stall) begin
                    w_epc_nxt     = redirect_valid ? w_redir_pc : w_seq_pc;
                    w_pc_nxt      = IRQ_VECTOR;
                    w_ie_nxt      = 1'b0;
                    w_irq_ack_nxt = 1'b1;
                    w_align_nxt   = 1'b0;
                end
`endif
                if (halt) begin
                    w_state_nxt = HALT;
                end
            end
            HALT: begin
                // A redirect while halted retargets the restart address
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_align_nxt = w_redir_misaligned;
                end
                if (resume) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // State and output registers; reset reloads the selected boot vector
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= BOOT;
            r_pc        <= w_boot_vec;
            r_pc_valid  <= 1'b0;
            r_align_err <= 1'b0;
`ifdef PC_IRQ_EN
            r_ie        <= 1'b1;
            r_irq_ack   <= 1'b0;
            r_epc       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pc_valid  <= (w_state_nxt == RUN);
            r_align_err <= w_align_nxt;
`ifdef PC_IRQ_EN
            r_ie        <= w_ie_nxt;
            r_irq_ack   <= w_irq_ack_nxt;
            r_epc       <= w_epc_nxt;
`endif
        end
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign align_err = r_align_err;
`ifdef PC_IRQ_EN
    assign irq_ack   = r_irq_ack;
    assign epc       = r_epc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               tracks mode/pc from the sequencing rules and is compared with
//               the DUT every cycle; directed literal checks pin the model.
//               Interrupt checks are included when PC_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  boot_sel;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] pc;
    logic        pc_valid;
    logic        align_err;
    logic [31:0] pc2;
    logic        pc_valid2;
    logic        align_err2;
`ifdef PC_IRQ_EN
    logic        irq;
    logic        eret;
    logic        irq_ack;
    logic [31:0] epc;
    logic        irq_ack2;
    logic [31:0] epc2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .boot_sel       (boot_sel),
        .stall          (stall),
        .halt           (halt),
        .resume         (resume),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .align_err      (align_err)
`ifdef PC_IRQ_EN
        ,
        .irq            (irq),
        .eret           (eret),
        .irq_ack        (irq_ack),
        .epc            (epc)
`endif
    );

    // Three-vector instance so that boot_sel=3 is out of range
    pc_sequencer #(
        .NUM_VECT     (3),
        .BOOT_VECTORS ({32'd25, 32'd15, 32'd0})
    ) dut2 (
        .clock          (clock),
        .reset          (reset),
        .boot_sel       (boot_sel),
        .stall          (stall),
        .halt           (halt),
        .resume         (resume),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pc             (pc2),
        .pc_valid       (pc_valid2),
        .align_err      (align_err2)
`ifdef PC_IRQ_EN
        ,
        .irq            (irq),
        .eret           (eret),
        .irq_ack        (irq_ack2),
        .epc            (epc2)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // mode: 0 = booting, 1 = running, 2 = halted
    int          m_mode  = 0;
    logic        m_known = 1'b0;
    logic [31:0] m_pc    = '0;
    logic        m_valid = 1'b0;
    logic        m_align = 1'b0;
    logic        m_ie    = 1'b1;
    logic        m_ack   = 1'b0;
    logic [31:0] m_epc   = '0;
    logic [31:0] t_target;
    int          t_next_mode;

    function automatic logic [31:0] boot_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return 32'd0;
            2'd1:    return 32'd15;
            2'd2:    return 32'd25;
            default: return 32'd75;
        endcase
    endfunction

    // Model advances on every rising edge from the inputs applied before it
    always @(posedge clock) begin
        if (reset) begin
            m_known = 1'b1;
            m_mode  = 0;
            m_pc    = boot_value(boot_sel);
            m_valid = 1'b0;
            m_align = 1'b0;
            m_ie    = 1'b1;
            m_ack   = 1'b0;
            m_epc   = '0;
        end else begin
            t_target    = redirect_addr & 32'hFFFF_FFFC;
            t_next_mode = m_mode;
            m_align     = 1'b0;
            m_ack       = 1'b0;
            if (m_mode == 0) begin
                t_next_mode = 1;
            end else if (m_mode == 1) begin
`ifdef PC_IRQ_EN
                if (eret) begin
                    m_pc = m_epc;
                    m_ie = 1'b1;
                end else if (irq && m_ie && !stall) begin
                    m_epc = redirect_valid ? t_target : m_pc + 32'd4;
                    m_pc  = 32'h80;
                    m_ie  = 1'b0;
                    m_ack = 1'b1;
                end else
`endif
                if (redirect_valid) begin
                    m_pc    = t_target;
                    m_align = (redirect_addr % 4) != 0;
                end else if (!stall) begin
                    m_pc = m_pc + 32'd4;
                end
                if (halt) t_next_mode = 2;
            end else begin
                if (redirect_valid) begin
                    m_pc    = t_target;
                    m_align = (redirect_addr % 4) != 0;
                end
                if (resume) t_next_mode = 1;
            end
            m_mode  = t_next_mode;
            m_valid = (m_mode == 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (m_known) begin
            chk("model_pc", pc, m_pc);
            chk("model_pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
            chk("model_align_err", {31'd0, align_err}, {31'd0, m_align});
`ifdef PC_IRQ_EN
            chk("model_irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
            chk("model_epc", epc, m_epc);
`endif
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive(input logic st, input logic hl, input logic rs,
                         input logic rv, input logic [31:0] ra);
        stall          = st;
        halt           = hl;
        resume         = rs;
        redirect_valid = rv;
        redirect_addr  = ra;
    endtask

    typedef struct packed {
        logic        st;
        logic        hl;
        logic        rs;
        logic        rv;
        logic [31:0] ra;
    } vec_t;

    vec_t tbl [0:9] = '{
        '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1236},
        '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b0, 1'b0, 1'b1, 32'h501},
        '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0},
        '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b0, 1'b1, 1'b1, 32'hABC},
        '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0}
    };

    initial begin
        reset    = 1'b1;
        boot_sel = 2'd1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PC_IRQ_EN
        irq  = 1'b0;
        eret = 1'b0;
`endif
        // Boot from vector 1
        tick();
        chk("boot_pc", pc, 32'd15);
        chk("boot_valid", {31'd0, pc_valid}, 32'd0);
        reset = 1'b0;
        tick();
        chk("run_first_pc", pc, 32'd15);
        chk("run_first_valid", {31'd0, pc_valid}, 32'd1);
        tick();
        chk("run_seq_pc", pc, 32'd19);

        // Stall holds the pc
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        chk("redir_100", pc, 32'h100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) begin
            tick();
            chk("stall_hold", pc, 32'h100);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("stall_release", pc, 32'h104);

        // Misaligned redirect under stall
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h203);
        tick();
        chk("misalign_pc", pc, 32'h200);
        chk("misalign_flag", {31'd0, align_err}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("misalign_next", pc, 32'h204);
        chk("misalign_pulse_end", {31'd0, align_err}, 32'd0);

        // Wrap at the top of the address space
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_valid", {31'd0, pc_valid}, 32'd1);

        // Halt, redirect while halted, resume (together with halt)
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        tick();
        chk("halt_start_pc", pc, 32'h40);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("halt_pc", pc, 32'h44);
        chk("halt_valid", {31'd0, pc_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        chk("halt_redir_pc", pc, 32'h80);
        chk("halt_redir_valid", {31'd0, pc_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("halt_hold_pc", pc, 32'h80);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("resume_valid", {31'd0, pc_valid}, 32'd1);
        chk("resume_pc", pc, 32'h80);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("resume_seq", pc, 32'h84);

        // Misaligned redirect while halted, then reset mid-halt
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h31);
        tick();
        chk("halt_misalign_pc", pc, 32'h30);
        chk("halt_misalign_flag", {31'd0, align_err}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset    = 1'b1;
        boot_sel = 2'd3;
        tick();
        chk("reset_halt_pc", pc, 32'd75);
        chk("reset_halt_align", {31'd0, align_err}, 32'd0);
        chk("oob_fallback_pc", pc2, 32'd0);
        boot_sel = 2'd2;
        tick();
        chk("boot2_pc", pc, 32'd25);
        chk("boot2_pc_small", pc2, 32'd25);
        reset = 1'b0;
        tick();
        tick();
        chk("boot2_seq", pc, 32'd29);

        // Reset during a stall
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        reset    = 1'b1;
        boot_sel = 2'd0;
        tick();
        chk("reset_stall_pc", pc, 32'd0);
        chk("reset_stall_valid", {31'd0, pc_valid}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Mixed control vectors, checked by the model
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].st, tbl[i].hl, tbl[i].rs, tbl[i].rv, tbl[i].ra);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

`ifdef PC_IRQ_EN
        // Interrupt entry, return, and a second entry
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        irq = 1'b1;
        tick();
        chk("irq_pc", pc, 32'h80);
        chk("irq_epc", epc, 32'h14);
        chk("irq_ack", {31'd0, irq_ack}, 32'd1);
        irq = 1'b0;
        tick();
        chk("irq_ack_end", {31'd0, irq_ack}, 32'd0);
        chk("irq_body_pc", pc, 32'h84);
        eret = 1'b1;
        tick();
        chk("eret_pc", pc, 32'h14);
        eret = 1'b0;
        irq  = 1'b1;
        tick();
        chk("irq2_pc", pc, 32'h80);
        chk("irq2_epc", epc, 32'h18);
        irq  = 1'b0;
        eret = 1'b1;
        tick();
        chk("eret2_pc", pc, 32'h18);
        eret = 1'b0;
        irq  = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("irq_stalled_pc", pc, 32'h18);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h303);
        tick();
        chk("irq_beats_redir_pc", pc, 32'h80);
        chk("irq_beats_redir_epc", epc, 32'h300);
        chk("irq_beats_redir_align", {31'd0, align_err}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        eret = 1'b1;
        tick();
        chk("eret3_pc", pc, 32'h300);
        irq  = 1'b0;
        eret = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
